// File: rtl/rs_err_correct_pp.sv
// Reed-Solomon error-correction stage with a ping-pong symbol buffer.
// Optional statistics counters are enabled by defining RS_CORR_STAT_EN.
module rs_err_correct_pp #(
  parameter int SYM_BW = 8,
  parameter int N_NUM  = 16,
  parameter int T_NUM  = 4,
  parameter int IDX_BW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [SYM_BW-1:0]        in_sym,
  input  logic                     err_vld,
  output logic                     err_rdy,
  input  logic [IDX_BW-1:0]        err_num,
  input  logic [IDX_BW*T_NUM-1:0]  err_loc,
  input  logic [SYM_BW*T_NUM-1:0]  err_val,
  input  logic                     dec_fail,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [SYM_BW-1:0]        out_sym,
  output logic [IDX_BW-1:0]        out_idx,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     out_fail
`ifdef RS_CORR_STAT_EN
  ,
  output logic [15:0]              corr_cnt,
  output logic [15:0]              fail_cnt
`endif
);

  localparam int                AW    = $clog2(N_NUM);
  localparam logic [IDX_BW-1:0] LAST  = IDX_BW'(N_NUM - 1);
  localparam logic [IDX_BW-1:0] T_MAX = IDX_BW'(T_NUM);

  typedef enum logic [2:0] {EMPTY, FILL, WAIT_ERR, READY, DRAIN} bank_st_t;

  typedef struct packed {
    logic [IDX_BW*T_NUM-1:0] loc;
    logic [SYM_BW*T_NUM-1:0] val;
    logic [IDX_BW-1:0]       num;
    logic                    fail;
  } desc_t;

  bank_st_t          st   [2];
  desc_t             desc [2];
  logic [SYM_BW-1:0] mem  [2][N_NUM];

  logic              wr_bank, err_bank, rd_bank;
  logic [IDX_BW-1:0] wr_idx, rd_idx;

  logic              s1_vld, s1_fail, s1_bank, s1_mod;
  logic [SYM_BW-1:0] s1_sym;
  logic [IDX_BW-1:0] s1_idx;
  logic              out_bank, out_mod;

  logic              en, fetch, hit, corr;
  logic [SYM_BW-1:0] hit_val;

  assign in_rdy  = !rst && (st[wr_bank] == EMPTY || st[wr_bank] == FILL);
  assign err_rdy = (st[err_bank] == WAIT_ERR);
  // Whole read pipeline stalls together, so a held output beat never changes.
  assign en      = !out_vld || out_rdy;
  assign fetch   = en && (st[rd_bank] == READY || st[rd_bank] == DRAIN);
  assign corr    = hit && !desc[rd_bank].fail;

  // NOTE: defaults first in always_comb so no path leaves a latch behind.
  always_comb begin
    hit     = 1'b0;
    hit_val = '0;
    // Descending scan: the lowest matching entry is written last and wins.
    for (int k = T_NUM - 1; k >= 0; k--) begin
      if (IDX_BW'(k) < desc[rd_bank].num &&
          desc[rd_bank].loc[k*IDX_BW +: IDX_BW] == rd_idx) begin
        hit     = 1'b1;
        hit_val = desc[rd_bank].val[k*SYM_BW +: SYM_BW];
      end
    end
  end

  // NOTE: the symbol store has no reset; every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (in_vld && in_rdy) mem[wr_bank][wr_idx[AW-1:0]] <= in_sym;
  end

  // NOTE: all state here uses non-blocking assignment so same-edge reads see old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= '{EMPTY, EMPTY};
      desc     <= '{'0, '0};
      wr_bank  <= 1'b0;
      err_bank <= 1'b0;
      rd_bank  <= 1'b0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      s1_vld   <= 1'b0;
      s1_sym   <= '0;
      s1_idx   <= '0;
      s1_fail  <= 1'b0;
      s1_bank  <= 1'b0;
      s1_mod   <= 1'b0;
      out_vld  <= 1'b0;
      out_sym  <= '0;
      out_idx  <= '0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      out_fail <= 1'b0;
      out_bank <= 1'b0;
      out_mod  <= 1'b0;
    end else begin
      if (in_vld && in_rdy) begin
        if (wr_idx == LAST) begin
          st[wr_bank] <= WAIT_ERR;
          wr_idx      <= '0;
          wr_bank     <= ~wr_bank;
        end else begin
          st[wr_bank] <= FILL;
          wr_idx      <= wr_idx + 1'b1;
        end
      end

      if (err_vld && err_rdy) begin
        desc[err_bank] <= '{loc:  err_loc,
                            val:  err_val,
                            num:  (err_num > T_MAX) ? T_MAX : err_num,
                            fail: dec_fail};
        st[err_bank]   <= READY;
        err_bank       <= ~err_bank;
      end

      if (en) begin
        out_vld  <= s1_vld;
        out_sym  <= s1_sym;
        out_idx  <= s1_idx;
        out_sop  <= s1_vld && (s1_idx == '0);
        out_eop  <= s1_vld && (s1_idx == LAST);
        out_fail <= s1_fail;
        out_bank <= s1_bank;
        out_mod  <= s1_mod;
        s1_vld   <= fetch;
        if (fetch) begin
          s1_sym      <= mem[rd_bank][rd_idx[AW-1:0]] ^ (corr ? hit_val : '0);
          s1_idx      <= rd_idx;
          s1_fail     <= desc[rd_bank].fail;
          s1_bank     <= rd_bank;
          s1_mod      <= corr && (hit_val != '0);
          st[rd_bank] <= DRAIN;
          if (rd_idx == LAST) begin
            rd_idx  <= '0;
            rd_bank <= ~rd_bank;
          end else begin
            rd_idx  <= rd_idx + 1'b1;
          end
        end
      end

      // Bank is released only once its last beat has left the output register.
      if (out_vld && out_rdy && out_eop) st[out_bank] <= EMPTY;
    end
  end

`ifdef RS_CORR_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt <= '0;
      fail_cnt <= '0;
    end else if (out_vld && out_rdy) begin
      if (out_mod && corr_cnt != 16'hFFFF)              corr_cnt <= corr_cnt + 16'd1;
      if (out_eop && out_fail && fail_cnt != 16'hFFFF)  fail_cnt <= fail_cnt + 16'd1;
    end
  end
`else
  logic unused_mod;
  assign unused_mod = out_mod;
`endif

endmodule

// File: tb/tb_rs_err_correct_pp.sv
// Self-checking bench for rs_err_correct_pp: directed and random blocks
// compared beat-by-beat against a list-based correction model.
module tb_rs_err_correct_pp;

  localparam int SYM_BW = 8;
  localparam int N_NUM  = 16;
  localparam int T_NUM  = 4;
  localparam int IDX_BW = 8;

  logic                    clk, rst;
  logic                    in_vld, in_rdy;
  logic [SYM_BW-1:0]       in_sym;
  logic                    err_vld, err_rdy;
  logic [IDX_BW-1:0]       err_num;
  logic [IDX_BW*T_NUM-1:0] err_loc;
  logic [SYM_BW*T_NUM-1:0] err_val;
  logic                    dec_fail;
  logic                    out_vld, out_rdy;
  logic [SYM_BW-1:0]       out_sym;
  logic [IDX_BW-1:0]       out_idx;
  logic                    out_sop, out_eop, out_fail;
`ifdef RS_CORR_STAT_EN
  logic [15:0]             corr_cnt, fail_cnt;
`endif

  rs_err_correct_pp #(.SYM_BW(SYM_BW), .N_NUM(N_NUM), .T_NUM(T_NUM), .IDX_BW(IDX_BW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_sym   (in_sym),
    .err_vld  (err_vld),
    .err_rdy  (err_rdy),
    .err_num  (err_num),
    .err_loc  (err_loc),
    .err_val  (err_val),
    .dec_fail (dec_fail),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_sym  (out_sym),
    .out_idx  (out_idx),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_fail (out_fail)
`ifdef RS_CORR_STAT_EN
    ,
    .corr_cnt (corr_cnt),
    .fail_cnt (fail_cnt)
`endif
  );

  typedef struct {
    logic [7:0] sym;
    int         idx;
    logic       fail;
    logic       mod;
  } beat_t;

  beat_t        exp_q[$];
  logic [127:0] pend_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int exp_corr = 0;
  int exp_fail = 0;
  int rdy_mode = 0;
  int bp_cnt   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: always, 1-of-3, or random.
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       begin bp_cnt = (bp_cnt + 1) % 3; out_rdy = (bp_cnt == 0); end
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: hold-stability while stalled and scoreboard on accepted beats.
  logic        held = 1'b0;
  logic [19:0] held_v;
  beat_t       e;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held)
        check("stall_hold", {out_vld, out_sop, out_eop, out_fail, out_idx, out_sym}, held_v);
      held   = out_vld && !out_rdy;
      held_v = {out_vld, out_sop, out_eop, out_fail, out_idx, out_sym};
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_vld, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("sym",  out_sym,  e.sym);
          check("idx",  out_idx,  e.idx);
          check("sop",  out_sop,  e.idx == 0);
          check("eop",  out_eop,  e.idx == N_NUM - 1);
          check("fail", out_fail, e.fail);
          if (e.mod) exp_corr++;
          if (e.idx == N_NUM - 1 && e.fail) exp_fail++;
        end
      end
    end
  end

  // Reference: apply the first valid list entry naming each position.
  task automatic push_expected(input logic [127:0] d, input int num,
                               input logic [31:0] loc, input logic [31:0] val, input logic fail);
    int n = (num > T_NUM) ? T_NUM : num;
    for (int i = 0; i < N_NUM; i++) begin
      beat_t b;
      b.sym  = d[i*8 +: 8];
      b.idx  = i;
      b.fail = fail;
      b.mod  = 1'b0;
      if (!fail) begin
        for (int k = 0; k < n; k++) begin
          if (int'(loc[k*8 +: 8]) == i) begin
            b.sym = b.sym ^ val[k*8 +: 8];
            b.mod = (val[k*8 +: 8] != 8'h00);
            break;
          end
        end
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic send_block(input logic [127:0] d);
    int tmo;
    for (int i = 0; i < N_NUM; i++) begin
      in_vld = 1'b1;
      in_sym = d[i*8 +: 8];
      tmo = 0;
      @(negedge clk);
      while (!in_rdy && tmo < 4000) begin @(negedge clk); tmo++; end
      if (!in_rdy) begin
        check("in_rdy_timeout", in_rdy, 1'b1);
        in_vld = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    pend_q.push_back(d);
  endtask

  task automatic send_err(input int num, input logic [31:0] loc, input logic [31:0] val, input logic fail);
    int tmo = 0;
    logic [127:0] d;
    err_vld  = 1'b1;
    err_num  = 8'(num);
    err_loc  = loc;
    err_val  = val;
    dec_fail = fail;
    @(negedge clk);
    while (!err_rdy && tmo < 4000) begin @(negedge clk); tmo++; end
    if (!err_rdy) begin
      check("err_rdy_timeout", err_rdy, 1'b1);
      err_vld = 1'b0;
      return;
    end
    @(posedge clk); #1;
    err_vld = 1'b0;
    d = pend_q.pop_front();
    push_expected(d, num, loc, val, fail);
  endtask

  task automatic wait_drain();
    int tmo = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && tmo < 4000) begin @(negedge clk); tmo++; end
    check("drain_complete", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] ramp_block(input logic [7:0] base);
    logic [127:0] d;
    for (int i = 0; i < N_NUM; i++) d[i*8 +: 8] = base + 8'(i);
    return d;
  endfunction

  logic [127:0] blk1, blk2, blk3;
  int           tmo;

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_sym = '0; err_vld = 1'b0;
    err_num = '0; err_loc = '0; err_val = '0; dec_fail = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy",  in_rdy,  1'b0);
    check("rst_err_rdy", err_rdy, 1'b0);
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_out_bus", {out_sym, out_idx, out_sop, out_eop, out_fail}, '0);
    #1 rst = 1'b0;
    #1 check("release_in_rdy", in_rdy, 1'b1);
    @(posedge clk); #1;

    // No errors, with first-beat latency
    send_block(ramp_block(8'h00));
    send_err(0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk); check("latency_cycle1", out_vld, 1'b0);
    @(negedge clk); check("latency_cycle2", out_vld, 1'b1);
    wait_drain();

    // Four errors at both ends of the block
    send_block(ramp_block(8'hA0));
    send_err(4, 32'h0F09_0500, 32'h4433_2211, 1'b0);
    wait_drain();

    // Count clamp, duplicate and out-of-range locations
    send_block(rand_block());
    send_err(2, 32'h0714_0303, 32'h0804_0201, 1'b0);
    wait_drain();
    send_block(rand_block());
    send_err(9, 32'h0303_1420, 32'h0804_0201, 1'b0);
    wait_drain();

    // Decode failure leaves data raw
    send_block(rand_block());
    send_err(4, 32'h0F09_0500, 32'h4433_2211, 1'b1);
    wait_drain();

    // Backpressure and ping-pong with three blocks
    rdy_mode = 1;
    blk1 = rand_block(); blk2 = rand_block(); blk3 = rand_block();
    send_block(blk1);
    send_block(blk2);
    @(negedge clk); check("in_rdy_both_full", in_rdy, 1'b0);
    @(posedge clk); #1;
    fork
      begin
        send_err(3, 32'h0002_0A01, 32'h0055_AA0F, 1'b0);
        send_err(1, 32'h0000_000F, 32'h0000_0080, 1'b0);
      end
      send_block(blk3);
    join
    send_err(4, {$urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)},
             $urandom, 1'b0);
    wait_drain();

    // Random blocks under random backpressure
    rdy_mode = 2;
    for (int b = 0; b < 6; b++) begin
      logic [31:0] loc;
      for (int k = 0; k < T_NUM; k++) loc[k*8 +: 8] = 8'($urandom_range(0, 19));
      send_block(rand_block());
      send_err(int'($urandom_range(0, 6)), loc, $urandom, ($urandom_range(0, 4) == 0));
    end
    wait_drain();

    // Reset in the middle of a drain
    rdy_mode = 0;
    send_block(rand_block());
    send_err(2, 32'h0000_0807, 32'h0000_3C5A, 1'b0);
    tmo = 0;
    @(negedge clk);
    while (!(out_vld && out_idx == 8'd7) && tmo < 200) begin @(negedge clk); tmo++; end
    check("reach_idx7", {out_vld, out_idx}, {1'b1, 8'd7});
    #2 rst = 1'b1;
    #1;
    check("midrst_out_vld", out_vld, 1'b0);
    check("midrst_out_bus", {out_sym, out_idx, out_sop, out_eop, out_fail}, '0);
    check("midrst_in_rdy",  in_rdy,  1'b0);
    check("midrst_err_rdy", err_rdy, 1'b0);
    exp_q.delete();
    pend_q.delete();
    exp_corr = 0;
    exp_fail = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    send_block(ramp_block(8'h40));
    send_err(2, 32'h0000_0C00, 32'h0000_F00F, 1'b0);
    wait_drain();
    send_block(rand_block());
    send_err(1, 32'h0000_0003, 32'h0000_0011, 1'b1);
    wait_drain();

    // Idle state at the end
    @(negedge clk);
    check("end_in_rdy",  in_rdy,  1'b1);
    check("end_err_rdy", err_rdy, 1'b0);
    check("end_out_vld", out_vld, 1'b0);
`ifdef RS_CORR_STAT_EN
    check("corr_cnt", corr_cnt, exp_corr);
    check("fail_cnt", fail_cnt, exp_fail);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
